// File: rtl/pacman_life_controller_pkg.sv
// pacman_life_controller_pkg: game state encodings and default timing/lives constants shared with HUD and movement blocks
package pacman_life_controller_pkg;
  typedef enum logic [1:0] {
    GS_IDLE      = 2'd0,
    GS_PLAYING   = 2'd1,
    GS_DYING     = 2'd2,
    GS_GAME_OVER = 2'd3
  } game_state_t;
  localparam int DEF_INIT_LIVES   = 3;
  localparam int DEF_LIVES_W      = 2;
  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_GRACE_FRAMES = 90;
  localparam int DEF_FRAME_CNT_W  = 7;
endpackage

// File: rtl/pacman_life_controller_frame_timer.sv
// pacman_life_controller_frame_timer: loadable down-counter stepped by frame ticks, done while it reads zero
module pacman_life_controller_frame_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/pacman_life_controller.sv
// pacman_life_controller: life counter, death hold-off, respawn grace window and game-over sequencing
module pacman_life_controller
  import pacman_life_controller_pkg::*;
#(
  parameter int INIT_LIVES   = DEF_INIT_LIVES,
  parameter int LIVES_W      = DEF_LIVES_W,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int GRACE_FRAMES = DEF_GRACE_FRAMES,
  parameter int FRAME_CNT_W  = DEF_FRAME_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pacman_is_dead,
  output logic [1:0]         state,
  output logic [LIVES_W-1:0] lives,
  output logic               freeze,
  output logic               respawn,
  output logic               death_pulse,
  output logic               game_over
);
  game_state_t st_q, st_n;
  logic [LIVES_W-1:0] lives_n;
  logic start_q, start_rise, respawn_n, death_pulse_n;
  logic grace_load, death_load, grace_done, death_done, death_exp;
  assign start_rise = start_btn & ~start_q;
  assign death_exp  = frame_tick & death_done;
  assign state      = st_q;
  // death timer is loaded with DEATH_FRAMES-1 so expiry lands on the DEATH_FRAMES-th tick
  pacman_life_controller_frame_timer #(.W(FRAME_CNT_W)) u_death (
    .clk(clk), .rst(rst), .load(death_load), .load_val(FRAME_CNT_W'(DEATH_FRAMES - 1)),
    .tick(frame_tick && st_q == GS_DYING), .done(death_done)
  );
  pacman_life_controller_frame_timer #(.W(FRAME_CNT_W)) u_grace (
    .clk(clk), .rst(rst), .load(grace_load), .load_val(FRAME_CNT_W'(GRACE_FRAMES)),
    .tick(frame_tick && st_q == GS_PLAYING), .done(grace_done)
  );
  always_comb begin
    st_n          = st_q;
    lives_n       = lives;
    respawn_n     = 1'b0;
    death_pulse_n = 1'b0;
    grace_load    = 1'b0;
    death_load    = 1'b0;
    unique case (st_q)
      GS_IDLE, GS_GAME_OVER: if (start_rise) begin
        st_n       = GS_PLAYING;
        lives_n    = LIVES_W'(INIT_LIVES);
        respawn_n  = 1'b1;
        grace_load = 1'b1;
      end
      GS_PLAYING: if (pacman_is_dead && grace_done) begin
        st_n          = GS_DYING;
        death_pulse_n = 1'b1;
        death_load    = 1'b1;
      end
      GS_DYING: if (death_exp) begin
        lives_n    = lives - LIVES_W'(1);
        st_n       = lives == LIVES_W'(1) ? GS_GAME_OVER : GS_PLAYING;
        respawn_n  = lives != LIVES_W'(1);
        grace_load = lives != LIVES_W'(1);
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q        <= GS_IDLE;
      lives       <= LIVES_W'(INIT_LIVES);
      freeze      <= 1'b1;
      respawn     <= 1'b0;
      death_pulse <= 1'b0;
      game_over   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      st_q        <= st_n;
      lives       <= lives_n;
      freeze      <= st_n != GS_PLAYING;
      respawn     <= respawn_n;
      death_pulse <= death_pulse_n;
      game_over   <= st_n == GS_GAME_OVER;
      start_q     <= start_btn;
    end
  always_ff @(posedge clk)
    if (!rst && st_q == GS_DYING && death_exp) assert (lives != '0);
endmodule

// File: tb/tb_pacman_life_controller.sv
// tb_pacman_life_controller: table-driven vectors plus cycle scoreboard against a spec-level model
module tb_pacman_life_controller;
  localparam int G = 4, D = 3, IL = 3;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, start_btn = 1'b0, pacman_is_dead = 1'b0;
  logic [1:0] state, lives;
  logic freeze, respawn, death_pulse, game_over;
  typedef struct packed {logic [1:0] st; logic [1:0] lv; logic fz, rs, dp, go;} outs_t;
  typedef struct {logic s, d, t; int n; outs_t e;} vec_t;
  vec_t vt[$];
  outs_t exp_q[$];
  outs_t got;
  int checks = 0, errors = 0;
  int m_st, m_lv, m_death, m_grace;
  logic m_sq, m_rs, m_dp;
  always #5 clk = ~clk;
  pacman_life_controller #(
    .INIT_LIVES(IL), .LIVES_W(2), .DEATH_FRAMES(D), .GRACE_FRAMES(G), .FRAME_CNT_W(7)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pacman_is_dead(pacman_is_dead), .state(state), .lives(lives), .freeze(freeze),
    .respawn(respawn), .death_pulse(death_pulse), .game_over(game_over)
  );
  function automatic outs_t actual();
    return {state, lives, freeze, respawn, death_pulse, game_over};
  endfunction
  task automatic check(input string name, input outs_t a, input outs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d lv=%0d fz/rs/dp/go=%b, want st=%0d lv=%0d fz/rs/dp/go=%b",
               name, a.st, a.lv, {a.fz, a.rs, a.dp, a.go}, e.st, e.lv, {e.fz, e.rs, e.dp, e.go});
    end
  endtask
  function automatic void m_reset();
    m_st = 0; m_lv = IL; m_death = 0; m_grace = 0; m_sq = 1'b0; m_rs = 1'b0; m_dp = 1'b0;
  endfunction
  function automatic outs_t m_step(input logic s, input logic d, input logic t);
    logic rise;
    rise = s & ~m_sq;
    m_sq = s; m_rs = 1'b0; m_dp = 1'b0;
    case (m_st)
      0, 3: if (rise) begin m_st = 1; m_lv = IL; m_grace = G; m_rs = 1'b1; end
      1: if (d && m_grace == 0) begin m_st = 2; m_dp = 1'b1; m_death = 0; end
         else if (t && m_grace > 0) m_grace--;
      default: if (t) begin
        if (m_death == D - 1) begin
          m_lv--;
          if (m_lv == 0) m_st = 3;
          else begin m_st = 1; m_rs = 1'b1; m_grace = G; end
        end else m_death++;
      end
    endcase
    return {2'(m_st), 2'(m_lv), m_st != 1, m_rs, m_dp, m_st == 3};
  endfunction
  task automatic cyc(input logic s, input logic d, input logic t, input string name, output outs_t g);
    start_btn = s; pacman_is_dead = d; frame_tick = t;
    exp_q.push_back(m_step(s, d, t));
    @(posedge clk);
    #1;
    g = actual();
    check(name, g, exp_q.pop_front());
  endtask
  function automatic void row(input logic s, input logic d, input logic t, input int n,
                              input logic [1:0] st, input logic [1:0] lv, input logic [3:0] f);
    vec_t v;
    v.s = s; v.d = d; v.t = t; v.n = n; v.e = {st, lv, f};
    vt.push_back(v);
  endfunction
  initial begin
    // start, dead, tick, cycles, then expected state/lives/{freeze,respawn,death_pulse,game_over} after the last cycle
    row(0, 0, 0, 2, 0, 3, 4'b1000);
    row(1, 0, 0, 1, 1, 3, 4'b0100);
    row(1, 1, 0, 1, 1, 3, 4'b0000);
    row(0, 1, 1, 4, 1, 3, 4'b0000);
    row(0, 1, 0, 1, 2, 3, 4'b1010);
    row(0, 0, 0, 1, 2, 3, 4'b1000);
    row(0, 0, 1, 2, 2, 3, 4'b1000);
    row(0, 0, 1, 1, 1, 2, 4'b0100);
    row(0, 1, 1, 4, 1, 2, 4'b0000);
    row(0, 1, 0, 1, 2, 2, 4'b1010);
    row(0, 0, 1, 3, 1, 1, 4'b0100);
    row(0, 1, 1, 4, 1, 1, 4'b0000);
    row(0, 1, 0, 1, 2, 1, 4'b1010);
    row(0, 0, 1, 3, 3, 0, 4'b1001);
    row(0, 0, 1, 3, 3, 0, 4'b1001);
    row(1, 0, 0, 1, 1, 3, 4'b0100);
    row(1, 1, 1, 4, 1, 3, 4'b0000);
    row(0, 1, 0, 1, 2, 3, 4'b1010);
    row(1, 0, 0, 1, 2, 3, 4'b1000);
    row(0, 0, 0, 1, 2, 3, 4'b1000);
    row(1, 0, 1, 3, 1, 2, 4'b0100);
    row(1, 0, 0, 3, 1, 2, 4'b0000);
    row(0, 1, 1, 4, 1, 2, 4'b0000);
    row(0, 1, 0, 1, 2, 2, 4'b1010);
    m_reset();
    #12;
    check("reset_values", actual(), {2'd0, 2'd3, 4'b1000});
    @(negedge clk);
    rst = 1'b0;
    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].n; k++) cyc(vt[i].s, vt[i].d, vt[i].t, $sformatf("row%0d.%0d", i, k), got);
      check($sformatf("row%0d_final", i), got, vt[i].e);
    end
    // asynchronous reset while DYING, asserted between clock edges
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mid_dying", actual(), {2'd0, 2'd3, 4'b1000});
    m_reset();
    @(negedge clk);
    check("rst_held", actual(), {2'd0, 2'd3, 4'b1000});
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, $sformatf("post_rst.%0d", k), got);
    check("post_rst_no_respawn", got, {2'd0, 2'd3, 4'b1000});
    cyc(1'b1, 1'b0, 1'b0, "restart", got);
    check("restart_after_rst", got, {2'd1, 2'd3, 4'b0100});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
